// File: rtl/store_drain_pkg.sv
// Shared types for the committed-store path: entry layout and drain FSM states.
package store_drain_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    // One committed store; layout shared with the store buffer.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] location;
        logic [DATA_W-1:0] data;
    } store_entry_t;

    typedef enum logic {
        DRAIN_IDLE  = 1'b0,
        DRAIN_ISSUE = 1'b1
    } drain_state_t;

endpackage

// File: rtl/store_drain_cam.sv
// Combinational youngest-match search over the drain FIFO for load forwarding.
module store_drain_cam
    import store_drain_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  store_entry_t      entries [DEPTH],
    input  logic [PTR_W-1:0]  head,
    input  logic [PTR_W:0]    count,
    input  logic [ADDR_W-1:0] key,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && entries[idx].valid &&
                (entries[idx].location == key)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_drain.sv
// Drains committed stores to the data-memory write port through a small
// write-combining FIFO, with a registered forwarding lookup for loads.
module store_drain
    import store_drain_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_location,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_wr_valid,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ready,
    input  logic [ADDR_W-1:0] search_location,
    output logic [DATA_W-1:0] search_data,
    output logic              search_valid,
    output logic              drain_empty,
    output logic              drain_full
);

    localparam int unsigned CNT_W = PTR_W + 1;

    store_entry_t      entries [DEPTH];
    drain_state_t      state;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  tail_last;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              pop_c;
    logic              loc_match_c;
    logic              combine_c;
    logic              push_c;
    logic              cam_hit;
    logic [DATA_W-1:0] cam_data;

    // Handshake decode; the issuing head is never a combine target.
    assign tail_last   = tail - PTR_W'(1);
    assign drain_full  = (count == CNT_W'(DEPTH));
    assign drain_empty = (count == '0) && !mem_wr_valid;
    assign pop_c       = mem_wr_valid && mem_wr_ready;
    assign loc_match_c = (count != '0) && entries[tail_last].valid &&
                         (entries[tail_last].location == in_location) &&
                         !(mem_wr_valid && (tail_last == head));
    assign in_ready    = !drain_full || pop_c || loc_match_c;
    assign combine_c   = in_valid && loc_match_c;
    assign push_c      = in_valid && in_ready && !combine_c;
    assign count_next  = count + CNT_W'(push_c) - CNT_W'(pop_c);

    assign mem_wr_addr = entries[head].location;
    assign mem_wr_data = entries[head].data;

    // Pointers, occupancy and the memory-port FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= DRAIN_IDLE;
            mem_wr_valid <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else begin
            count <= count_next;
            if (push_c) tail <= tail + PTR_W'(1);
            if (pop_c)  head <= head + PTR_W'(1);
            case (state)
                DRAIN_IDLE: begin
                    if (count_next != '0) begin
                        state        <= DRAIN_ISSUE;
                        mem_wr_valid <= 1'b1;
                    end
                end
                DRAIN_ISSUE: begin
                    if (pop_c && (count_next == '0)) begin
                        state        <= DRAIN_IDLE;
                        mem_wr_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= DRAIN_IDLE;
                    mem_wr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Entry storage; a push into the slot being popped (full case) wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[PTR_W'(i)] <= '0;
            end
        end else begin
            if (pop_c)     entries[head].valid     <= 1'b0;
            if (combine_c) entries[tail_last].data <= in_data;
            if (push_c)    entries[tail]           <= {1'b1, in_location, in_data};
        end
    end

    store_drain_cam #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_cam (
        .entries (entries),
        .head    (head),
        .count   (count),
        .key     (search_location),
        .hit     (cam_hit),
        .data    (cam_data)
    );

    // Forwarding result register; data holds its last value on a miss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            search_valid <= 1'b0;
            search_data  <= '0;
        end else begin
            search_valid <= cam_hit;
            if (cam_hit) search_data <= cam_data;
        end
    end

endmodule

// File: tb/tb_store_drain.sv
// Self-checking bench for store_drain against a queue-based reference model.
module tb_store_drain;

    localparam int DEPTH = 8;

    typedef struct {
        logic [15:0] loc;
        logic [15:0] dat;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_location;
    logic [15:0] in_data;
    logic        in_ready;
    logic        mem_wr_valid;
    logic [15:0] mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        mem_wr_ready;
    logic [15:0] search_location;
    logic [15:0] search_data;
    logic        search_valid;
    logic        drain_empty;
    logic        drain_full;

    int compared   = 0;
    int mismatched = 0;

    ent_t        q[$];
    bit          m_issue;
    logic        m_sv;
    logic [15:0] m_sd;

    store_drain #(.DEPTH(8), .PTR_W(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_location     (in_location),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .mem_wr_valid    (mem_wr_valid),
        .mem_wr_addr     (mem_wr_addr),
        .mem_wr_data     (mem_wr_data),
        .mem_wr_ready    (mem_wr_ready),
        .search_location (search_location),
        .search_data     (search_data),
        .search_valid    (search_valid),
        .drain_empty     (drain_empty),
        .drain_full      (drain_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check mid-cycle, advance model after posedge.
    task automatic step(input logic v, input logic [15:0] loc, input logic [15:0] dat,
                        input logic rdy, input logic [15:0] sloc);
        bit          pop;
        bit          match;
        bit          comb;
        bit          ir;
        bit          hit;
        logic [15:0] hd;
        in_valid        = v;
        in_location     = loc;
        in_data         = dat;
        mem_wr_ready    = rdy;
        search_location = sloc;
        #1;
        pop   = m_issue && rdy;
        match = 1'b0;
        if (q.size() > 0)
            match = (q[q.size()-1].loc == loc) && !(m_issue && q.size() == 1);
        ir   = (q.size() < DEPTH) || pop || match;
        comb = v && match;
        chk("in_ready", in_ready, ir);
        chk("wr_valid", mem_wr_valid, m_issue);
        if (m_issue) begin
            chk("wr_addr", mem_wr_addr, q[0].loc);
            chk("wr_data", mem_wr_data, q[0].dat);
        end
        chk("drain_empty", drain_empty, (q.size() == 0) && !m_issue);
        chk("drain_full", drain_full, q.size() == DEPTH);
        chk("search_valid", search_valid, m_sv);
        chk("search_data", search_data, m_sd);
        @(posedge clk);
        hit = 1'b0;
        hd  = '0;
        foreach (q[i]) begin
            if (q[i].loc == sloc) begin
                hit = 1'b1;
                hd  = q[i].dat;
            end
        end
        m_sv = hit;
        if (hit) m_sd = hd;
        if (comb) q[q.size()-1].dat = dat;
        if (pop) void'(q.pop_front());
        if (v && ir && !comb) q.push_back('{loc, dat});
        m_issue = (q.size() > 0);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
    endtask

    // Reset asserted between clock edges; outputs must react without a clock.
    task automatic async_reset();
        in_valid     = 1'b0;
        mem_wr_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_wr_valid", mem_wr_valid, 1'b0);
        chk("rst_drain_empty", drain_empty, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_drain_full", drain_full, 1'b0);
        chk("rst_search_valid", search_valid, 1'b0);
        chk("rst_search_data", search_data, 16'h0000);
        q.delete();
        m_issue = 1'b0;
        m_sv    = 1'b0;
        m_sd    = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        in_valid        = 1'b0;
        in_location     = '0;
        in_data         = '0;
        mem_wr_ready    = 1'b0;
        search_location = '0;
        m_issue         = 1'b0;
        m_sv            = 1'b0;
        m_sd            = '0;
        repeat (2) @(negedge clk);
        chk("init_wr_valid", mem_wr_valid, 1'b0);
        chk("init_drain_empty", drain_empty, 1'b1);
        chk("init_in_ready", in_ready, 1'b1);
        chk("init_search_valid", search_valid, 1'b0);
        reset = 1'b0;

        // Single store reaches memory the cycle after acceptance.
        step(1'b1, 16'h0010, 16'hAAAA, 1'b1, 16'h0000);
        chk("t1_wr_valid", mem_wr_valid, 1'b1);
        chk("t1_wr_addr", mem_wr_addr, 16'h0010);
        chk("t1_wr_data", mem_wr_data, 16'hAAAA);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        chk("t1_drain_empty", drain_empty, 1'b1);

        // Fill to full with memory stalled, then push through a same-cycle pop.
        for (int i = 0; i < 8; i++)
            step(1'b1, 16'h0100 + 16'(i), 16'hC000 + 16'(i), 1'b0, 16'h0000);
        in_valid    = 1'b1;
        in_location = 16'h0200;
        #1;
        chk("t2_full", drain_full, 1'b1);
        chk("t2_in_ready", in_ready, 1'b0);
        step(1'b1, 16'h0200, 16'hBEEF, 1'b0, 16'h0000);
        step(1'b1, 16'h0200, 16'hBEEF, 1'b1, 16'h0000);
        chk("t2_still_full", drain_full, 1'b1);
        drain(10);

        // Write-combine into the youngest non-issuing entry.
        step(1'b1, 16'h0030, 16'h1111, 1'b0, 16'h0000);
        step(1'b1, 16'h0040, 16'h2222, 1'b0, 16'h0000);
        step(1'b1, 16'h0040, 16'h3333, 1'b0, 16'h0000);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        drain(4);

        // No combine into the issuing head; data stable while stalled.
        step(1'b1, 16'h0050, 16'h1234, 1'b0, 16'h0000);
        step(1'b1, 16'h0050, 16'h5678, 1'b0, 16'h0000);
        repeat (3) step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        drain(4);

        // Forwarding returns the youngest matching entry.
        step(1'b1, 16'h0060, 16'h0001, 1'b0, 16'h0000);
        step(1'b1, 16'h0061, 16'h00AA, 1'b0, 16'h0000);
        step(1'b1, 16'h0060, 16'h0002, 1'b0, 16'h0000);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0060);
        chk("t5_fwd_valid", search_valid, 1'b1);
        chk("t5_fwd_data", search_data, 16'h0002);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0070);
        chk("t5_miss_valid", search_valid, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

        // Asynchronous reset while issuing with three entries.
        async_reset();
        step(1'b1, 16'h0090, 16'h9999, 1'b1, 16'h0000);
        drain(3);
        for (int i = 0; i < 20; i++)
            step(1'b1, 16'h0A00 + 16'(i), 16'(i * 7), 1'b1, 16'h0A00 + 16'(i));
        drain(4);

        // Randomized traffic over a small address set to hit combines and wraps.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 5)),
                 16'($urandom), ($urandom_range(0, 3) != 0),
                 16'h0100 + 16'($urandom_range(0, 7)));
        drain(12);
        chk("final_empty", drain_empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
